isa_io_capture: RTL and testbench
=================================

ISA_IO_CAPTURE -- requirements
Module: isa_io_capture

Interface
REQ-001 SHALL have parameters: NUM_WIN, default 2, number of I/O windows (1..4).
REQ-002 SHALL have parameter WIN_BASE, default {10'h388,10'h340}, packed 10-bit base per window, window 0 in the LSBs.
REQ-003 SHALL have parameter WIN_MASK, default {10'h001,10'h007}, packed 10-bit don't-care mask per window; each mask is at most 10'h007.
REQ-004 SHALL have parameter RD_EN, default 2'b11, per-window readback enable.
REQ-005 SHALL have parameter FIFO_AW, default 12, so FIFO depth is 2^FIFO_AW.
REQ-006 SHALL have parameter AF_LEVEL, default 2^FIFO_AW-16, the almost-full threshold.
REQ-007 SHALL have parameter WAIT_MAX, default 511, the maximum CHRDY hold in clk cycles.
REQ-008 SHALL have ports, clock and reset first:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- isa_a  in  10  ISA address
- isa_d_i  in  8  ISA data in
- isa_d_o  out  8  ISA data out
- isa_d_oe  out  1  data-bus drive enable
- isa_iow  in  1  ISA IOW, active-low
- isa_ior  in  1  ISA IOR, active-low
- isa_aen  in  1  ISA AEN, high = DMA cycle
- isa_chrdy_oe  out  1  when 1, pad drives CHRDY low
- out_data  out  18  {address[9:0], data[7:0]}
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accept
- level  out  FIFO_AW+1  FIFO occupancy
- overflow_cnt  out  16  dropped-write count, saturating
- hit_win  out  2  window index of the last captured write

Function
REQ-009 SHALL pass isa_iow and isa_ior through 2-flop synchronisers; edges are detected on the synchronised copies.
REQ-010 SHALL register isa_a, isa_d_i and isa_aen every clk while synchronised IOW is low.
- The values held at the IOW rising edge are "the cycle".
REQ-011 A cycle SHALL hit window w when aen=0 and (a & ~WIN_MASK[w]) == (WIN_BASE[w] & ~WIN_MASK[w]).
- The lowest matching w wins.
REQ-012 On an IOW rising edge with a hit:
- SHALL push {a,d} to the FIFO.
- SHALL write d to shadow[w][a & WIN_MASK[w]].
- SHALL update hit_win.
- All three happen in the same clk.
REQ-013 If the FIFO is full at push and no pop occurs that cycle, SHALL drop the entry and increment overflow_cnt, saturating at 16'hFFFF.
- The shadow write still occurs.
REQ-014 SHALL provide a show-ahead FIFO:
- out_data is valid whenever out_valid=1.
- Pop occurs when out_valid && out_ready.
REQ-015 Simultaneous push and pop on a full FIFO SHALL accept both; level is unchanged.
REQ-016 Simultaneous push and pop on an empty FIFO SHALL perform the push only.
- out_valid rises the next cycle.
REQ-017 level SHALL equal pushes minus pops, registered.
- Pointers wrap modulo 2^FIFO_AW.
- Full is level == 2^FIFO_AW.
REQ-018 Wait-state FSM states: IDLE, WAIT, HOLD.
- IDLE->WAIT on an IOW falling edge with a hit (decoded from live isa_a/isa_aen) while level >= AF_LEVEL. WAIT sets isa_chrdy_oe=1 and loads a counter with WAIT_MAX.
- WAIT->HOLD when level < AF_LEVEL or the counter reaches 0. HOLD sets isa_chrdy_oe=0.
- HOLD->IDLE on the IOW rising edge.
- IDLE->IDLE otherwise.
REQ-019 isa_chrdy_oe SHALL be 1 only in WAIT.
REQ-020 On an IOR falling edge with aen=0 and a hit on a window with RD_EN[w]=1:
- SHALL set isa_d_o = shadow[w][a & WIN_MASK[w]] and isa_d_oe=1 on the next clk.
REQ-021 SHALL clear isa_d_oe on the synchronised IOR rising edge.
- isa_d_oe never asserts for a miss, for aen=1, or for RD_EN[w]=0.
REQ-022 IOW and IOR edges in the same clk SHALL both be processed independently.

Reset
REQ-023 rst_n=0 SHALL asynchronously clear:
- FIFO pointers, level and overflow_cnt;
- shadow RAM;
- synchronisers;
- isa_d_o, isa_d_oe, isa_chrdy_oe, hit_win and out_valid to 0;
- the FSM to IDLE.
REQ-024 Reset asserted mid-cycle SHALL release CHRDY and the data bus immediately.
- An IOW rising edge arriving after reset deassertion without a preceding low sample SHALL NOT push.

Verification
REQ-025 Write 8'hA5 to 10'h389 with out_ready=0:
- level=1.
- out_data=18'h389A5 → {10'h389, 8'hA5}.
- hit_win=1.
REQ-026 Write 8'h42 to 10'h343, then read 10'h343:
- isa_d_oe=1 and isa_d_o=8'h42.
- A read of 10'h348 leaves isa_d_oe=0.
REQ-027 Write to 10'h341 with isa_aen=1:
- No push, shadow unchanged, no CHRDY.
REQ-028 Fill the FIFO to 2^FIFO_AW, then issue 3 further writes:
- overflow_cnt=3 and level unchanged.
- Then write while out_ready=1: level stays full and overflow_cnt stays 3.
REQ-029 With level=AF_LEVEL, start an IOW:
- isa_chrdy_oe=1.
- Pop 1 entry → chrdy_oe=0 within 2 clk.
- With no pops, chrdy_oe=0 after WAIT_MAX+1 clk.
REQ-030 Assert rst_n=0 during WAIT:
- isa_chrdy_oe=0, level=0 and out_valid=0 in the same cycle.

Source files
------------

// File: rtl/isa_io_capture.sv
// isa_io_capture
// Snoops ISA I/O writes that fall into up to four decoded address windows.
// Every hit is pushed as {address, data} into a show-ahead FIFO and stored in
// a small per-window shadow RAM. Reads of a window can be answered from that
// shadow RAM. When the FIFO nears full, CHRDY is held low to stretch the ISA
// write until the consumer drains entries or a timeout expires.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   isa_a           ISA address (10 bit)
//   isa_d_i         ISA data in
//   isa_d_o         ISA data out
//   isa_d_oe        ISA data drive enable
//   isa_iow         ISA IOW strobe (active low)
//   isa_ior         ISA IOR strobe (active low)
//   isa_aen         ISA AEN (high = DMA cycle, never decoded)
//   isa_chrdy_oe    1 = pad pulls CHRDY low (wait state)
//   out_data        FIFO head, {address[9:0], data[7:0]}
//   out_valid       FIFO non-empty
//   out_ready       consumer accepts the head entry
//   level           FIFO occupancy
//   overflow_cnt    saturating count of writes dropped on a full FIFO
//   hit_win         window index of the last captured write
module isa_io_capture #(
  parameter int unsigned           NUM_WIN  = 2,
  parameter logic [NUM_WIN*10-1:0] WIN_BASE = {10'h388, 10'h340},
  parameter logic [NUM_WIN*10-1:0] WIN_MASK = {10'h001, 10'h007},
  parameter logic [NUM_WIN-1:0]    RD_EN    = 2'b11,
  parameter int unsigned           FIFO_AW  = 12,
  parameter int unsigned           AF_LEVEL = (1 << FIFO_AW) - 16,
  parameter int unsigned           WAIT_MAX = 511
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         isa_a,
  input  logic [7:0]         isa_d_i,
  output logic [7:0]         isa_d_o,
  output logic               isa_d_oe,
  input  logic               isa_iow,
  input  logic               isa_ior,
  input  logic               isa_aen,
  output logic               isa_chrdy_oe,
  output logic [17:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIFO_AW:0]   level,
  output logic [15:0]        overflow_cnt,
  output logic [1:0]         hit_win
);

  localparam int unsigned      DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] AF_LVL   = (FIFO_AW+1)'(AF_LEVEL);
  localparam int unsigned      WCW      = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  // ---------------- strobe synchronisers and edge detection ----------------
  logic iow_s1_q, iow_s2_q, iow_s3_q;
  logic ior_s1_q, ior_s2_q, ior_s3_q;
  // Marks which synchroniser stages hold real pin samples since reset, so the
  // cleared reset contents never masquerade as a strobe edge.
  logic [2:0] sync_vld_q;
  logic iow_fall, iow_rise, ior_fall, ior_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iow_s1_q   <= 1'b0;
      iow_s2_q   <= 1'b0;
      iow_s3_q   <= 1'b0;
      ior_s1_q   <= 1'b0;
      ior_s2_q   <= 1'b0;
      ior_s3_q   <= 1'b0;
      sync_vld_q <= 3'b000;
    end else begin
      iow_s1_q   <= isa_iow;
      iow_s2_q   <= iow_s1_q;
      iow_s3_q   <= iow_s2_q;
      ior_s1_q   <= isa_ior;
      ior_s2_q   <= ior_s1_q;
      ior_s3_q   <= ior_s2_q;
      sync_vld_q <= {sync_vld_q[1:0], 1'b1};
    end
  end

  assign iow_fall = sync_vld_q[2] &  iow_s3_q & ~iow_s2_q;
  assign iow_rise = sync_vld_q[2] & ~iow_s3_q &  iow_s2_q;
  assign ior_fall = sync_vld_q[2] &  ior_s3_q & ~ior_s2_q;
  assign ior_rise = sync_vld_q[2] & ~ior_s3_q &  ior_s2_q;

  // ---------------- write-cycle capture ----------------
  logic [9:0] cap_a_q;
  logic [7:0] cap_d_q;
  logic       cap_aen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_a_q   <= 10'd0;
      cap_d_q   <= 8'd0;
      cap_aen_q <= 1'b1;
    end else if (sync_vld_q[1] && !iow_s2_q) begin
      cap_a_q   <= isa_a;
      cap_d_q   <= isa_d_i;
      cap_aen_q <= isa_aen;
    end
  end

  // ---------------- window decode ----------------
  logic [NUM_WIN-1:0] cap_match, live_match;

  generate
    for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
      localparam logic [9:0] BASE = WIN_BASE[gi*10 +: 10];
      localparam logic [9:0] MASK = WIN_MASK[gi*10 +: 10];
      assign cap_match[gi]  = ((cap_a_q & ~MASK) == (BASE & ~MASK));
      assign live_match[gi] = ((isa_a   & ~MASK) == (BASE & ~MASK));
    end
  endgenerate

  logic       cap_hit, live_hit, live_rd;
  logic [1:0] cap_win, live_win;
  logic [2:0] cap_off, live_off;

  // Scanning from the top down leaves the lowest matching window selected.
  always_comb begin
    cap_hit  = 1'b0;
    cap_win  = 2'd0;
    cap_off  = 3'd0;
    live_hit = 1'b0;
    live_win = 2'd0;
    live_off = 3'd0;
    live_rd  = 1'b0;
    for (int w = NUM_WIN - 1; w >= 0; w--) begin
      if (cap_match[w]) begin
        cap_hit = 1'b1;
        cap_win = 2'(w);
        cap_off = cap_a_q[2:0] & WIN_MASK[w*10 +: 3];
      end
      if (live_match[w]) begin
        live_hit = 1'b1;
        live_win = 2'(w);
        live_off = isa_a[2:0] & WIN_MASK[w*10 +: 3];
        live_rd  = RD_EN[w];
      end
    end
    cap_hit  = cap_hit  & ~cap_aen_q;
    live_hit = live_hit & ~isa_aen;
  end

  logic wr_ev;
  assign wr_ev = iow_rise & cap_hit;

  // ---------------- show-ahead FIFO ----------------
  logic [17:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_addr_d;
  logic [FIFO_AW:0]   level_q;
  logic [15:0]        ovf_q;
  logic [17:0]        push_data, ram_rd_q, byp_data_q;
  logic               byp_q, fifo_full, pop, push, drop;

  assign push_data = {cap_a_q, cap_d_q};
  assign fifo_full = (level_q == FULL_LVL);
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  assign push      = wr_ev & (~fifo_full | pop);
  assign drop      = wr_ev & fifo_full & ~pop;
  // Address of the entry that will be at the head after this clock.
  assign rd_addr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
    ram_rd_q <= fifo_mem[rd_addr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 16'd0;
      byp_q      <= 1'b0;
      byp_data_q <= 18'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      rd_ptr_q <= rd_addr_d;
      case ({push, pop})
        2'b10:   level_q <= level_q + (FIFO_AW+1)'(1);
        2'b01:   level_q <= level_q - (FIFO_AW+1)'(1);
        default: level_q <= level_q;
      endcase
      if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
      // The RAM read above returns stale data when the next head is being
      // written this very clock; forward the pushed word instead.
      byp_q      <= push && (wr_ptr_q == rd_addr_d);
      byp_data_q <= push_data;
    end
  end

  assign out_data     = byp_q ? byp_data_q : ram_rd_q;
  assign level        = level_q;
  assign overflow_cnt = ovf_q;

  // ---------------- shadow RAM and readback ----------------
  // Fixed 4 windows x 8 bytes so {window, offset} indexes it directly.
  logic [7:0] shadow_q [32];
  logic [7:0] d_o_q;
  logic       d_oe_q;
  logic [1:0] hit_win_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= 8'd0;
      d_o_q     <= 8'd0;
      d_oe_q    <= 1'b0;
      hit_win_q <= 2'd0;
    end else begin
      if (wr_ev) begin
        shadow_q[{cap_win, cap_off}] <= cap_d_q;
        hit_win_q                    <= cap_win;
      end
      if (ior_rise) begin
        d_oe_q <= 1'b0;
      end else if (ior_fall && live_hit && live_rd) begin
        d_oe_q <= 1'b1;
        d_o_q  <= shadow_q[{live_win, live_off}];
      end
    end
  end

  assign isa_d_o  = d_o_q;
  assign isa_d_oe = d_oe_q;
  assign hit_win  = hit_win_q;

  // ---------------- CHRDY wait-state FSM ----------------
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;
  state_t         state_q;
  logic [WCW-1:0] wcnt_q;
  logic           chrdy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      chrdy_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iow_fall && live_hit && level_q >= AF_LVL) begin
            state_q <= ST_WAIT;
            wcnt_q  <= WCW'(WAIT_MAX);
            chrdy_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          // A host ignoring CHRDY ends the cycle anyway; go straight to idle.
          if (iow_rise) begin
            state_q <= ST_IDLE;
            chrdy_q <= 1'b0;
          end else if (level_q < AF_LVL || wcnt_q == '0) begin
            state_q <= ST_HOLD;
            chrdy_q <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q - WCW'(1);
          end
        end
        ST_HOLD: begin
          if (iow_rise) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          chrdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign isa_chrdy_oe = chrdy_q;

endmodule

// File: tb/tb_isa_io_capture.sv
// Directed bench for isa_io_capture: 16-deep FIFO, almost-full at 12,
// CHRDY timeout of 20 clocks, default two windows (0x340/7 and 0x388/1).
module tb_isa_io_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  isa_a = 10'd0;
  logic [7:0]  isa_d_i = 8'd0;
  logic [7:0]  isa_d_o;
  logic        isa_d_oe;
  logic        isa_iow = 1'b1;
  logic        isa_ior = 1'b1;
  logic        isa_aen = 1'b0;
  logic        isa_chrdy_oe;
  logic [17:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  level;
  logic [15:0] overflow_cnt;
  logic [1:0]  hit_win;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  isa_io_capture #(
    .FIFO_AW (4),
    .AF_LEVEL(12),
    .WAIT_MAX(20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .isa_a       (isa_a),
    .isa_d_i     (isa_d_i),
    .isa_d_o     (isa_d_o),
    .isa_d_oe    (isa_d_oe),
    .isa_iow     (isa_iow),
    .isa_ior     (isa_ior),
    .isa_aen     (isa_aen),
    .isa_chrdy_oe(isa_chrdy_oe),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .overflow_cnt(overflow_cnt),
    .hit_win     (hit_win)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One ISA write; stall returns the number of sampled clocks CHRDY was held.
  // pop_at_push pulses out_ready exactly on the clock that pushes the entry.
  task automatic isa_write(input logic [9:0] a, input logic [7:0] d, input logic aen,
                           input logic pop_at_push, output int stall);
    isa_a = a; isa_d_i = d; isa_aen = aen;
    @(negedge clk);
    isa_iow = 1'b0;
    stall = 0;
    for (int i = 0; i < 8 && !isa_chrdy_oe; i++) @(negedge clk);
    while (isa_chrdy_oe && stall < 200) begin
      stall++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    isa_iow = 1'b1;
    if (pop_at_push) begin
      repeat (2) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    $display("write a=%h d=%h aen=%0d stall=%0d level=%0d ovf=%0d", a, d, aen, stall, level, overflow_cnt);
  endtask

  task automatic isa_read(input logic [9:0] a, input logic aen,
                          output logic oe, output logic [7:0] dout, output logic oe_after);
    isa_a = a; isa_aen = aen;
    @(negedge clk);
    isa_ior = 1'b0;
    repeat (6) @(negedge clk);
    oe = isa_d_oe; dout = isa_d_o;
    isa_ior = 1'b1;
    repeat (6) @(negedge clk);
    oe_after = isa_d_oe;
    $display("read  a=%h aen=%0d oe=%0d d=%h oe_after=%0d", a, aen, oe, dout, oe_after);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("pop   level=%0d head=%h", level, out_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         st;
    logic       oe, oe_after;
    logic [7:0] dout;

    repeat (3) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow_cnt, 0);
    chk("rst_chrdy", isa_chrdy_oe, 0);
    chk("rst_doe", isa_d_oe, 0);
    chk("rst_dout", isa_d_o, 0);
    chk("rst_hitwin", hit_win, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_push_after_release", level, 0);

    // First capture into window 1
    isa_write(10'h389, 8'hA5, 1'b0, 1'b0, st);
    chk("w389_level", level, 1);
    chk("w389_valid", out_valid, 1);
    chk("w389_data", out_data, 18'h389A5);
    chk("w389_hitwin", hit_win, 1);
    chk("w389_stall", st, 0);

    // DMA cycle is ignored
    isa_write(10'h341, 8'h77, 1'b1, 1'b0, st);
    chk("aen_level", level, 1);
    chk("aen_hitwin", hit_win, 1);
    chk("aen_stall", st, 0);

    // Window 0 write and readbacks
    isa_write(10'h343, 8'h42, 1'b0, 1'b0, st);
    chk("w343_level", level, 2);
    chk("w343_hitwin", hit_win, 0);
    chk("w343_head", out_data, 18'h389A5);
    isa_read(10'h343, 1'b0, oe, dout, oe_after);
    chk("r343_oe", oe, 1);
    chk("r343_data", dout, 8'h42);
    chk("r343_oe_release", oe_after, 0);
    isa_read(10'h348, 1'b0, oe, dout, oe_after);
    chk("r348_miss_oe", oe, 0);
    isa_read(10'h389, 1'b0, oe, dout, oe_after);
    chk("r389_oe", oe, 1);
    chk("r389_data", dout, 8'hA5);
    isa_read(10'h343, 1'b1, oe, dout, oe_after);
    chk("r343_aen_oe", oe, 0);
    isa_read(10'h341, 1'b0, oe, dout, oe_after);
    chk("r341_oe", oe, 1);
    chk("r341_shadow_untouched", dout, 8'h00);

    // Drain
    pop_one();
    chk("pop1_head", out_data, 18'h34342);
    chk("pop1_level", level, 1);
    pop_one();
    chk("pop2_level", level, 0);
    chk("pop2_valid", out_valid, 0);

    // Fill to 16; writes starting at level 12 time out after 21 clocks
    for (int i = 0; i < 16; i++) begin
      isa_write(10'h340 + 10'(i % 8), 8'h10 + 8'(i), 1'b0, 1'b0, st);
      if (i == 11) chk("fill11_stall", st, 0);
      if (i == 12) chk("fill12_stall", st, 21);
    end
    chk("full_level", level, 16);
    chk("full_head", out_data, {10'h340, 8'h10});

    for (int k = 0; k < 3; k++) isa_write(10'h345, 8'hE0 + 8'(k), 1'b0, 1'b0, st);
    chk("ovf_cnt", overflow_cnt, 3);
    chk("ovf_level", level, 16);
    isa_read(10'h345, 1'b0, oe, dout, oe_after);
    chk("ovf_shadow", dout, 8'hE2);

    // Push and pop together on a full FIFO
    isa_write(10'h346, 8'hC3, 1'b0, 1'b1, st);
    chk("pp_level", level, 16);
    chk("pp_ovf", overflow_cnt, 3);
    chk("pp_head", out_data, {10'h341, 8'h11});

    // Almost-full stall released by a pop
    repeat (4) pop_one();
    chk("af_level", level, 12);
    isa_a = 10'h342; isa_d_i = 8'h5A; isa_aen = 1'b0;
    @(negedge clk);
    isa_iow = 1'b0;
    for (int i = 0; i < 8 && !isa_chrdy_oe; i++) @(negedge clk);
    chk("af_chrdy_on", isa_chrdy_oe, 1);
    pop_one();
    @(negedge clk);
    chk("af_chrdy_off", isa_chrdy_oe, 0);
    chk("af_level_after_pop", level, 11);
    isa_iow = 1'b1;
    repeat (6) @(negedge clk);
    chk("af_push", level, 12);

    // Reset during a wait state
    isa_a = 10'h343; isa_d_i = 8'h99;
    @(negedge clk);
    isa_iow = 1'b0;
    for (int i = 0; i < 8 && !isa_chrdy_oe; i++) @(negedge clk);
    chk("rw_chrdy_on", isa_chrdy_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_chrdy", isa_chrdy_oe, 0);
    chk("rw_level", level, 0);
    chk("rw_valid", out_valid, 0);
    chk("rw_ovf", overflow_cnt, 0);
    @(negedge clk);
    isa_iow = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rw_no_push", level, 0);
    isa_read(10'h343, 1'b0, oe, dout, oe_after);
    chk("rw_shadow_oe", oe, 1);
    chk("rw_shadow_cleared", dout, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
